radix4_booth_ctrl: RTL and testbench
====================================

# radix4_booth_ctrl

Sequencing controller for the radix-4 Booth multiplier datapath. It accepts a start request, loads the operands, and walks the datapath through WIDTH/2 evaluate/add/shift iterations driven by the current Booth triplet. It then signals completion. It sits between the system-level start/done handshake and the multiplier's register, adder and shifter enables.

## Interface
- WIDTH, 8: operand width in bits. Must be even and ≥4. ITER = WIDTH/2 iterations.
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  start request; sampled only in IDLE
- booth_bits  in  3  current triplet {Q[1],Q[0],Q[-1]} from the datapath multiplier register
- ld  out  1  load multiplicand/multiplier, clear accumulator and Q[-1]
- op_en  out  1  accumulator write enable (add/sub stage)
- op_sel  out  2  addend select: 0 = zero, 1 = M, 2 = 2M
- op_sub  out  1  1 = subtract addend
- shift_en  out  1  arithmetic right shift of {acc,Q,Q[-1]} by 2
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; product valid in the datapath
- cnt  out  $clog2(ITER)  current iteration index

## Operation
- States (3-bit encoding): IDLE=000, LOAD=001, EVAL=010, ADD=011, SHIFT=100, DONE=101. Encodings 110 and 111 are illegal and go to IDLE.
- IDLE: all outputs 0, cnt held at 0. go=1 → LOAD.
- LOAD: ld=1, cnt←0 → EVAL.
- EVAL: decode booth_bits into registered op_sel/op_sub.
  - 000, 111 → zero; go to SHIFT (add skipped).
  - 001, 010 → +M.
  - 011 → +2M.
  - 100 → −2M.
  - 101, 110 → −M.
  - Every non-zero code → ADD.
- ADD: op_en=1, with the registered op_sel and op_sub → SHIFT.
- SHIFT: shift_en=1.
  - If cnt==ITER−1 → DONE.
  - Otherwise cnt←cnt+1 → EVAL.
- DONE: done=1 for one cycle → IDLE. If go is still high in the following IDLE cycle, a new operation starts; there is no requirement for go to drop between operations.
- go is ignored in every state except IDLE. booth_bits is ignored outside EVAL.
- op_sel and op_sub hold their last value outside ADD. Their value is only meaningful while op_en=1.
- Outputs ld, op_en, shift_en, busy and done are Moore-decoded from the state register.

## Timing
- Reset: any cycle with rst=1 → state IDLE and cnt=0, op_sel=0, op_sub=0 at the next edge. rst has priority over all transitions, including mid-iteration. Outputs are 0 from that edge onward.
- go sampled high at edge k gives this sequence:
  - LOAD during cycle k+1.
  - First EVAL at k+2.
  - DONE after the final SHIFT.
- Latency, go edge to done cycle: 2 + 2·ITER + (number of non-zero triplets). WIDTH=8 gives 10 cycles minimum and 14 maximum.
- Exactly one ld pulse and exactly ITER shift_en pulses per operation. There are at most ITER op_en pulses.
- ld, op_en and shift_en are mutually exclusive in every cycle.

## Structure
- Package radix4_pkg holds:
  - the state encodings;
  - the op_sel codes (SEL_ZERO, SEL_M, SEL_2M);
  - the rule ITER = WIDTH/2.
- Sub-module booth_decode: combinational 3-bit triplet → {op_sel, op_sub, nonzero}. The datapath's partial-product mux uses the same sub-module.
- Top: state register, iteration counter, registered op fields and output decode. Target 150–250 lines.

## Test plan
- Reset: rst high for 2 cycles with go=1 → state IDLE and all outputs 0. With rst low and go=1 → ld=1 on the next cycle.
- All-zero multiplier, WIDTH=8: go pulse, with booth_bits=000 on every EVAL. Required: ld, then 4 shift_en pulses, no op_en, done at cycle 10 after go, cnt stepping 0..3.
- Triplet coverage: drive 011, 100, 101 and 001 on successive EVALs. Required op_en with op_sel/op_sub of 2/0, 2/1, 1/1 and 1/0 respectively, and done at cycle 14.
- go toggled during busy: no effect on the sequence. Exactly one done is produced.
- rst asserted in ADD of iteration 2: IDLE on the next edge, no done. A following go gives a clean full-length operation with cnt starting at 0.
- go held high continuously: the done cycle is followed by IDLE (1 cycle) and then LOAD. Two operations complete, each with correct pulse counts.

Source files
------------

// File: rtl/radix4_pkg.sv
// Shared definitions for the radix-4 Booth multiplier controller and datapath:
// state encodings, addend-select codes and the iteration-count rule.
package radix4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b000,
      ST_LOAD  = 3'b001,
      ST_EVAL  = 3'b010,
      ST_ADD   = 3'b011,
      ST_SHIFT = 3'b100,
      ST_DONE  = 3'b101
   } state_t;

   localparam logic [1:0] SEL_ZERO = 2'd0;
   localparam logic [1:0] SEL_M    = 2'd1;
   localparam logic [1:0] SEL_2M   = 2'd2;

   // Each radix-4 step retires two multiplier bits.
   function automatic int iter_of(input int width);
      return width / 2;
   endfunction

endpackage

// File: rtl/booth_decode.sv
// Radix-4 Booth recoding of one triplet {Q[1],Q[0],Q[-1]} into addend select,
// subtract flag and a non-zero indication; shared with the partial-product mux.
module booth_decode
   import radix4_pkg::*;
(
   input  logic [2:0] booth_bits_i,
   output logic [1:0] op_sel_o,
   output logic       op_sub_o,
   output logic       nonzero_o
);

   always_comb begin
      op_sel_o  = SEL_ZERO;
      op_sub_o  = 1'b0;
      nonzero_o = 1'b0;
      unique case (booth_bits_i)
         3'b001, 3'b010: begin op_sel_o = SEL_M;  op_sub_o = 1'b0; nonzero_o = 1'b1; end
         3'b011:         begin op_sel_o = SEL_2M; op_sub_o = 1'b0; nonzero_o = 1'b1; end
         3'b100:         begin op_sel_o = SEL_2M; op_sub_o = 1'b1; nonzero_o = 1'b1; end
         3'b101, 3'b110: begin op_sel_o = SEL_M;  op_sub_o = 1'b1; nonzero_o = 1'b1; end
         default:        ;
      endcase
   end

endmodule

// File: rtl/radix4_booth_ctrl.sv
// Sequencing controller for the radix-4 Booth multiplier: load, then WIDTH/2
// evaluate/add/shift iterations, then a one-cycle done pulse.
module radix4_booth_ctrl
   import radix4_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int ITER  = iter_of(WIDTH),
   localparam int CNT_W = $clog2(ITER)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             go_i,
   input  logic [2:0]       booth_bits_i,
   output logic             ld_o,
   output logic             op_en_o,
   output logic [1:0]       op_sel_o,
   output logic             op_sub_o,
   output logic             shift_en_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [1:0]       op_sel_q, op_sel_d;
   logic             op_sub_q, op_sub_d;

   logic [1:0] dec_sel;
   logic       dec_sub;
   logic       dec_nonzero;

   booth_decode u_decode (
      .booth_bits_i (booth_bits_i),
      .op_sel_o     (dec_sel),
      .op_sub_o     (dec_sub),
      .nonzero_o    (dec_nonzero)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         op_sel_q <= SEL_ZERO;
         op_sub_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_sel_q <= op_sel_d;
         op_sub_q <= op_sub_d;
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_sel_d = op_sel_q;
      op_sub_d = op_sub_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (go_i) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_EVAL;
         end
         ST_EVAL: begin
            op_sel_d = dec_sel;
            op_sub_d = dec_sub;
            state_d  = dec_nonzero ? ST_ADD : ST_SHIFT;
         end
         ST_ADD: state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_DONE;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
               state_d = ST_EVAL;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         // Encodings 110/111 recover to IDLE.
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      ld_o       = 1'b0;
      op_en_o    = 1'b0;
      shift_en_o = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         ST_LOAD:  begin ld_o       = 1'b1; busy_o = 1'b1; end
         ST_EVAL:  begin                    busy_o = 1'b1; end
         ST_ADD:   begin op_en_o    = 1'b1; busy_o = 1'b1; end
         ST_SHIFT: begin shift_en_o = 1'b1; busy_o = 1'b1; end
         ST_DONE:  begin done_o     = 1'b1; busy_o = 1'b1; end
         default:  ;
      endcase
   end

   assign op_sel_o = op_sel_q;
   assign op_sub_o = op_sub_q;
   assign cnt_o    = cnt_q;

endmodule

// File: tb/tb_radix4_booth_ctrl.sv
// Directed bench for radix4_booth_ctrl (WIDTH=8): each operation is described by
// four hand-decoded triplets and checked cycle by cycle against the expected trace.
module tb_radix4_booth_ctrl;

   localparam int WIDTH = 8;
   localparam int ITER  = 4;

   // Output vector order: {ld, op_en, shift_en, busy, done}
   localparam logic [7:0] O_IDLE  = 8'b000_00000;
   localparam logic [7:0] O_LOAD  = 8'b000_10010;
   localparam logic [7:0] O_EVAL  = 8'b000_00010;
   localparam logic [7:0] O_ADD   = 8'b000_01010;
   localparam logic [7:0] O_SHIFT = 8'b000_00110;
   localparam logic [7:0] O_DONE  = 8'b000_00011;

   typedef struct packed {
      logic [2:0] trip;
      logic [1:0] sel;
      logic       sub;
      logic       nz;
   } vec_t;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       go_i;
   logic [2:0] booth_bits_i;
   logic       ld_o, op_en_o, op_sub_o, shift_en_o, busy_o, done_o;
   logic [1:0] op_sel_o;
   logic [1:0] cnt_o;

   int total = 0;
   int bad   = 0;

   radix4_booth_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .go_i         (go_i),
      .booth_bits_i (booth_bits_i),
      .ld_o         (ld_o),
      .op_en_o      (op_en_o),
      .op_sel_o     (op_sel_o),
      .op_sub_o     (op_sub_o),
      .shift_en_o   (shift_en_o),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .cnt_o        (cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [7:0] outs();
      return {3'b000, ld_o, op_en_o, shift_en_o, busy_o, done_o};
   endfunction

   function automatic logic go_val(input int mode, input int cyc);
      if (mode == 2) return 1'b1;
      if (mode == 1) return cyc[0];
      return 1'b0;
   endfunction

   function automatic vec_t mk(input logic [2:0] trip, input logic [1:0] sel,
                               input logic sub, input logic nz);
      return '{trip: trip, sel: sel, sub: sub, nz: nz};
   endfunction

   task automatic idle_cycles(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         go_i = 1'b0;
         check($sformatf("%s/idle%0d", tag, k), outs(), O_IDLE);
         step();
      end
   endtask

   // Starts from an IDLE cycle. go_mode: 0 pulse, 1 toggling while busy, 2 held high.
   // abort_iter >= 0 asserts rst during the ADD cycle of that iteration.
   task automatic run_op(input string tag, input vec_t [ITER-1:0] v,
                         input int go_mode, input int abort_iter);
      int cyc  = 0;
      int n_ld = 0, n_op = 0, n_sh = 0, n_nz = 0;
      check($sformatf("%s/pre_idle", tag), outs(), O_IDLE);
      check($sformatf("%s/pre_cnt", tag), {6'b0, cnt_o}, 8'd0);
      go_i = 1'b1;
      step();

      go_i = go_val(go_mode, cyc++);
      booth_bits_i = 3'b011;
      check($sformatf("%s/load", tag), outs(), O_LOAD);
      check($sformatf("%s/load_cnt", tag), {6'b0, cnt_o}, 8'd0);
      n_ld += int'(ld_o);
      step();

      for (int i = 0; i < ITER; i++) begin
         go_i = go_val(go_mode, cyc++);
         booth_bits_i = v[i].trip;
         check($sformatf("%s/eval%0d", tag, i), outs(), O_EVAL);
         check($sformatf("%s/eval%0d_cnt", tag, i), {6'b0, cnt_o}, 8'(i));
         step();
         booth_bits_i = ~v[i].trip;
         if (v[i].nz) begin
            n_nz++;
            go_i = go_val(go_mode, cyc++);
            check($sformatf("%s/add%0d", tag, i), outs(), O_ADD);
            check($sformatf("%s/add%0d_sel_sub", tag, i), {5'b0, op_sel_o, op_sub_o},
                  {5'b0, v[i].sel, v[i].sub});
            check($sformatf("%s/add%0d_cnt", tag, i), {6'b0, cnt_o}, 8'(i));
            n_op += int'(op_en_o);
            if (i == abort_iter) begin
               rst_i = 1'b1;
               go_i  = 1'b0;
               step();
               rst_i = 1'b0;
               check($sformatf("%s/abort_outs", tag), outs(), O_IDLE);
               check($sformatf("%s/abort_cnt_sel_sub", tag),
                     {3'b0, cnt_o, op_sel_o, op_sub_o}, 8'd0);
               return;
            end
            step();
         end
         go_i = go_val(go_mode, cyc++);
         check($sformatf("%s/shift%0d", tag, i), outs(), O_SHIFT);
         check($sformatf("%s/shift%0d_cnt", tag, i), {6'b0, cnt_o}, 8'(i));
         n_sh += int'(shift_en_o);
         step();
      end

      go_i = (go_mode == 2);
      check($sformatf("%s/done", tag), outs(), O_DONE);
      check($sformatf("%s/done_cnt", tag), {6'b0, cnt_o}, 8'(ITER - 1));
      step();
      check($sformatf("%s/n_ld", tag), 8'(n_ld), 8'd1);
      check($sformatf("%s/n_shift", tag), 8'(n_sh), 8'(ITER));
      check($sformatf("%s/n_op_en", tag), 8'(n_op), 8'(n_nz));
   endtask

   vec_t [ITER-1:0] v;

   initial begin
      rst_i        = 1'b1;
      go_i         = 1'b1;
      booth_bits_i = 3'b011;

      // Reset held two cycles with go high.
      step();
      check("rst_c0_outs", outs(), O_IDLE);
      step();
      check("rst_c1_outs", outs(), O_IDLE);
      check("rst_cnt_sel_sub", {3'b0, cnt_o, op_sel_o, op_sub_o}, 8'd0);
      rst_i = 1'b0;
      step();
      check("rst_release_load", outs(), O_LOAD);
      rst_i = 1'b1;
      go_i  = 1'b0;
      step();
      rst_i = 1'b0;
      idle_cycles("post_rst", 2);

      // All-zero multiplier: latency 10.
      v[0] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      v[1] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      v[2] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      v[3] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      run_op("zero", v, 0, -1);
      idle_cycles("zero_after", 2);

      // Triplet coverage: latency 14.
      v[0] = mk(3'b011, 2'd2, 1'b0, 1'b1);
      v[1] = mk(3'b100, 2'd2, 1'b1, 1'b1);
      v[2] = mk(3'b101, 2'd1, 1'b1, 1'b1);
      v[3] = mk(3'b001, 2'd1, 1'b0, 1'b1);
      run_op("cover", v, 0, -1);
      idle_cycles("cover_after", 2);

      // Remaining codes with go toggling while busy; exactly one done.
      v[0] = mk(3'b010, 2'd1, 1'b0, 1'b1);
      v[1] = mk(3'b111, 2'd0, 1'b0, 1'b0);
      v[2] = mk(3'b110, 2'd1, 1'b1, 1'b1);
      v[3] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      run_op("toggle", v, 1, -1);
      idle_cycles("toggle_after", 3);

      // Reset in the ADD cycle of iteration 2, then a clean full operation.
      v[0] = mk(3'b001, 2'd1, 1'b0, 1'b1);
      v[1] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      v[2] = mk(3'b110, 2'd1, 1'b1, 1'b1);
      v[3] = mk(3'b011, 2'd2, 1'b0, 1'b1);
      run_op("abort", v, 0, 2);
      idle_cycles("abort_after", 3);
      v[0] = mk(3'b100, 2'd2, 1'b1, 1'b1);
      v[1] = mk(3'b011, 2'd2, 1'b0, 1'b1);
      v[2] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      v[3] = mk(3'b010, 2'd1, 1'b0, 1'b1);
      run_op("recover", v, 0, -1);
      idle_cycles("recover_after", 2);

      // go held high: DONE, one IDLE cycle, then LOAD of the next operation.
      v[0] = mk(3'b101, 2'd1, 1'b1, 1'b1);
      v[1] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      v[2] = mk(3'b001, 2'd1, 1'b0, 1'b1);
      v[3] = mk(3'b111, 2'd0, 1'b0, 1'b0);
      run_op("held_a", v, 2, -1);
      v[0] = mk(3'b110, 2'd1, 1'b1, 1'b1);
      v[1] = mk(3'b011, 2'd2, 1'b0, 1'b1);
      v[2] = mk(3'b100, 2'd2, 1'b1, 1'b1);
      v[3] = mk(3'b000, 2'd0, 1'b0, 1'b0);
      run_op("held_b", v, 2, -1);
      idle_cycles("held_after", 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
